// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  // Bulk-clear sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_LINK_REG = 31;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: entry select plus zero / link-bypass /
// write-bypass priority mux.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int LINK_REG = RF_LINK_REG
) (
  input  logic [ADDR_W-1:0]               i_addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   i_mem_flat,
  input  logic                            i_wr_en,
  input  logic [ADDR_W-1:0]               i_wr_addr,
  input  logic [DATA_W-1:0]               i_wr_data,
  input  logic                            i_link_en,
  input  logic [DATA_W-1:0]               i_link_data,
  output logic [DATA_W-1:0]               o_data
);

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] w_stored;

  assign w_stored = i_mem_flat[i_addr*DATA_W +: DATA_W];

  // Zero register beats link bypass, which beats general write bypass
  always_comb begin
    o_data = w_stored;
    if (ZERO_REG != 0 && i_addr == '0) begin
      o_data = '0;
    end else if (BYPASS != 0 && i_link_en && i_addr == LINK_A) begin
      o_data = i_link_data;
    end else if (BYPASS != 0 && i_wr_en && i_addr == i_wr_addr) begin
      o_data = i_wr_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with link write port, registered debug
// read and a one-entry-per-cycle bulk-clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int LINK_REG = RF_LINK_REG
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_link_en,
  input  logic [DATA_W-1:0]          i_link_data,
  input  logic                       i_clr_req,
  output logic                       o_busy,
  input  logic [ADDR_W-1:0]          i_dbg_addr,
  output logic [DATA_W-1:0]          o_dbg_data
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH-1);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0]       r_mem [DEPTH];
  rf_state_e               r_state;
  logic [ADDR_W:0]         r_cnt;
  logic [DATA_W-1:0]       r_dbg_data;
  logic [DEPTH*DATA_W-1:0] w_mem_flat;
  logic                    w_busy;
  logic                    w_wr_en;
  logic                    w_link_en;

  assign w_busy    = (r_state == ST_CLEAR);
  // Both write ports, and therefore their bypass, are dead while sweeping
  assign w_wr_en   = i_wr_en   & ~w_busy;
  assign w_link_en = i_link_en & ~w_busy;

  assign o_busy     = w_busy;
  assign o_dbg_data = r_dbg_data;

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign w_mem_flat[e*DATA_W +: DATA_W] = r_mem[e];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .LINK_REG (LINK_REG)
    ) u_rd (
      .i_addr      (i_rd_addr[k*ADDR_W +: ADDR_W]),
      .i_mem_flat  (w_mem_flat),
      .i_wr_en     (w_wr_en),
      .i_wr_addr   (i_wr_addr),
      .i_wr_data   (i_wr_data),
      .i_link_en   (w_link_en),
      .i_link_data (i_link_data),
      .o_data      (o_rd_data[k*DATA_W +: DATA_W])
    );
  end

  // Storage, write ports, clear sequencer and debug register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= r_mem[i_dbg_addr];
      case (r_state)
        ST_IDLE: begin
          // Link port owns LINK_REG when both ports target it
          if (i_wr_en && !(ZERO_REG != 0 && i_wr_addr == '0) &&
              !(i_link_en && i_wr_addr == LINK_A)) begin
            r_mem[i_wr_addr] <= i_wr_data;
          end
          if (i_link_en && !(ZERO_REG != 0 && LINK_A == '0)) begin
            r_mem[LINK_A] <= i_link_data;
          end
          if (i_clr_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_mem[r_cnt[ADDR_W-1:0]] <= '0;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed checks of regfile_mp against an array model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [NR*AW-1:0]  i_rd_addr;
  logic [NR*DW-1:0]  o_rd_data;
  logic              i_wr_en;
  logic [AW-1:0]     i_wr_addr;
  logic [DW-1:0]     i_wr_data;
  logic              i_link_en;
  logic [DW-1:0]     i_link_data;
  logic              i_clr_req;
  logic              o_busy;
  logic [AW-1:0]     i_dbg_addr;
  logic [DW-1:0]     o_dbg_data;

  regfile_mp dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_link_en   (i_link_en),
    .i_link_data (i_link_data),
    .i_clr_req   (i_clr_req),
    .o_busy      (o_busy),
    .i_dbg_addr  (i_dbg_addr),
    .o_dbg_data  (o_dbg_data)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: array of entries, a busy flag and the next entry to clear
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_sweep;
  logic [DW-1:0] m_dbg;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input int a);
    if (a == 0) return '0;
    if (!m_busy && i_link_en && a == 31) return i_link_data;
    if (!m_busy && i_wr_en && a == int'(i_wr_addr)) return i_wr_data;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) m_mem[e] = '0;
    m_busy  = 0;
    m_sweep = 0;
    m_dbg   = '0;
  endtask

  task automatic model_edge();
    if (i_reset) begin
      model_reset();
    end else begin
      m_dbg = m_mem[i_dbg_addr];
      if (m_busy) begin
        m_mem[m_sweep] = '0;
        if (m_sweep == DEPTH - 1) m_busy = 0;
        else m_sweep++;
      end else begin
        if (i_wr_en && i_wr_addr != 0) m_mem[i_wr_addr] = i_wr_data;
        if (i_link_en) m_mem[31] = i_link_data;
        if (i_clr_req) begin
          m_busy  = 1;
          m_sweep = 0;
        end
      end
    end
  endtask

  // Check the combinational and registered outputs, then advance one edge
  task automatic tick();
    #3;
    for (int k = 0; k < NR; k++)
      chk($sformatf("rd%0d@%0d", k, i_rd_addr[k*AW +: AW]),
          o_rd_data[k*DW +: DW], ref_read(int'(i_rd_addr[k*AW +: AW])));
    chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
    chk("dbg", o_dbg_data, m_dbg);
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_reset   = 0;
    i_wr_en   = 0;
    i_link_en = 0;
    i_clr_req = 0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_link_data = '0;
    i_dbg_addr = AW'($urandom_range(0, 31));
    i_rd_addr  = NR*AW'($urandom);
  endtask

  task automatic set_rd(input int a0, input int a1);
    i_rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Pulse clr_req and count busy cycles (bounded), optionally dropping a write
  task automatic sweep(output int n_busy);
    idle_inputs();
    i_clr_req = 1;
    tick();
    i_clr_req = 0;
    n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_busy) n_busy++;
      idle_inputs();
      if (c == 4) set_rd(3, 20);
      if (c == 6) begin
        i_wr_en = 1; i_wr_addr = 5'd10; i_wr_data = 32'hFFFF_FFFF;
        set_rd(10, 11);
      end
      if (c == 8) i_clr_req = 1;
      tick();
    end
  endtask

  task automatic scan_all();
    for (int a = 0; a < DEPTH; a += 2) begin
      idle_inputs();
      set_rd(a, a + 1);
      i_dbg_addr = AW'(a);
      tick();
    end
  endtask

  int n_busy;

  initial begin
    idle_inputs();
    i_reset = 1;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    model_reset();

    // Post-reset reads
    idle_inputs(); i_reset = 1; set_rd(0, 5); tick();
    idle_inputs(); set_rd(31, 5); tick();
    chk("rst_rd31", o_rd_data[DW-1:0], 32'h0);

    // Same-cycle bypass of a general write
    idle_inputs();
    i_wr_en = 1; i_wr_addr = 5'd7; i_wr_data = 32'hDEAD_BEEF; set_rd(7, 0);
    #3 chk("bypass7", o_rd_data[DW-1:0], 32'hDEAD_BEEF);
    #(-0) tick();
    idle_inputs(); set_rd(7, 7); tick();

    // Writes to entry 0 are discarded
    idle_inputs();
    i_wr_en = 1; i_wr_addr = 5'd0; i_wr_data = 32'h1234_5678; set_rd(0, 7);
    tick();
    idle_inputs(); set_rd(0, 0); i_dbg_addr = '0; tick();
    chk("zero_after", o_rd_data[DW-1:0], 32'h0);

    // Link port wins over a general write to the link register
    idle_inputs();
    i_wr_en = 1; i_wr_addr = 5'd31; i_wr_data = 32'hAAAA_0000;
    i_link_en = 1; i_link_data = 32'h0040_0010; set_rd(31, 31);
    tick();
    idle_inputs(); set_rd(31, 0); i_dbg_addr = 5'd31; tick();
    chk("link_after", o_rd_data[DW-1:0], 32'h0040_0010);

    // Fill 1..31 with their index, then sweep
    for (int a = 1; a < DEPTH; a++) begin
      idle_inputs();
      i_wr_en = 1; i_wr_addr = AW'(a); i_wr_data = DW'(a);
      tick();
    end
    scan_all();
    sweep(n_busy);
    chk("busy_len", DW'(n_busy), 32'd32);
    scan_all();

    // Reset in the middle of a sweep, then a full sweep again
    for (int a = 1; a < DEPTH; a++) begin
      idle_inputs();
      i_wr_en = 1; i_wr_addr = AW'(a); i_wr_data = 32'h5A00_0000 | DW'(a);
      tick();
    end
    idle_inputs(); i_clr_req = 1; tick();
    for (int c = 0; c < 10; c++) begin idle_inputs(); tick(); end
    idle_inputs(); i_reset = 1; tick();
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    scan_all();
    sweep(n_busy);
    chk("busy_len2", DW'(n_busy), 32'd32);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      i_reset     = ($urandom_range(0, 199) == 0);
      i_wr_en     = $urandom_range(0, 1) == 1;
      i_wr_addr   = AW'($urandom);
      i_wr_data   = $urandom;
      i_link_en   = $urandom_range(0, 3) == 0;
      i_link_data = $urandom;
      i_clr_req   = $urandom_range(0, 59) == 0;
      if ($urandom_range(0, 3) == 0) set_rd(int'(i_wr_addr), 31);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the MIPS datapath. It provides:
- N combinational read ports with write-through bypass.
- One general write port.
- A dedicated link write port for jal.
- An optional hardwired zero register.
- A registered debug read port.
- A sequenced bulk-clear engine.

It sits between decode (read) and writeback (write) and reports busy while clearing.

Parameters:
DATA_W, 32, data width of each entry
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
LINK_REG, 31, entry written by the link port

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
wr_en  in  1  general write enable
wr_addr  in  ADDR_W  general write address
wr_data  in  DATA_W  general write data
link_en  in  1  link write enable (jal)
link_data  in  DATA_W  return address to store in LINK_REG
clr_req  in  1  single-cycle pulse: start sequenced clear
busy  out  1  high while clear sequence is running
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  registered debug read data

Behaviour:
- Reset (synchronous, active-high):
  - All entries become 0.
  - FSM goes to IDLE; busy=0; dbg_data=0; clear counter=0.
  - Reset overrides every other input, including mid-clear.
  - After reset, rd_data reads 0 on every port.
- Writes take effect at the rising edge:
  - wr_en=1 writes wr_data to entry wr_addr.
  - link_en=1 writes link_data to entry LINK_REG.
  - Both enabled with wr_addr==LINK_REG: link port wins, link_data is stored.
  - Both enabled with different addresses: both writes occur.
- ZERO_REG=1:
  - Writes to entry 0 from either port are discarded.
  - Reads of address 0 return 0, bypass included.
- Reads are combinational, zero latency. Per-port priority:
  1. Address 0 with ZERO_REG → 0.
  2. BYPASS and link_en and addr==LINK_REG → link_data.
  3. BYPASS and wr_en and addr==wr_addr → wr_data.
  4. Otherwise → stored entry.
- BYPASS=0: reads return pre-edge stored contents only.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_req=1; counter loads 0; busy=1 from the next cycle.
  - In CLEAR, each cycle writes 0 to entry[counter], then counter increments.
  - When counter==2**ADDR_W-1, that entry is cleared and the FSM returns to IDLE. busy=0 on the following cycle.
  - Total busy cycles = 2**ADDR_W.
  - clr_req while in CLEAR is ignored.
  - wr_en and link_en are ignored while busy=1; no bypass is applied either.
  - Reads during CLEAR return the current array contents: cleared entries read 0, uncleared entries keep their old value.
  - Counter wraps only by returning to IDLE; it never re-sweeps.
- Debug port: dbg_data <= entry[dbg_addr] each rising edge. One-cycle latency, pre-write contents (no bypass).
- Widths:
  - No arithmetic on data.
  - Counter is ADDR_W+1 bits wide to detect the end without overflow.
  - Out-of-range parameters (NUM_RD<1) are rejected by elaboration-time assertion.

Decomposition:
- Package regfile_pkg holds:
  - FSM state typedef (IDLE, CLEAR).
  - Default DATA_W/ADDR_W constants.
  - LINK_REG default.
- Sub-module rf_read_port: one address decode plus the zero/bypass priority mux. It is instantiated NUM_RD times in a generate loop.
- The storage array, write logic, clear FSM and debug register stay in regfile_mp.

Test Plan:
- Reset, then read all ports at addresses 0, 5, 31 → all read 0x00000000. busy=0, dbg_data=0.
- Write 0xDEADBEEF to 7 with rd_addr port0=7 in the same cycle → port0 shows 0xDEADBEEF combinationally (bypass). With BYPASS=0 it shows 0 until after the edge.
- Write 0x12345678 to 0 → port reading 0 returns 0 in the write cycle and afterwards.
- wr_en to 31 with 0xAAAA0000 and link_en with 0x00400010 in the same cycle → read 31 returns 0x00400010 in that cycle and after.
- Fill entries 1..31 with their index, pulse clr_req →
  - busy high for exactly 32 cycles.
  - Entry 3 reads 0 after 4 busy cycles while entry 20 still reads 20.
  - A wr_en to 10 during busy is dropped.
  - All entries read 0 at the end.
- Start a clear, assert reset at busy cycle 10 → next cycle busy=0, all entries 0, FSM IDLE. A subsequent clr_req restarts the full 32-cycle sweep.
